// File: rtl/arm7tdmi_fetch_if.sv
// rtl/arm7tdmi_fetch_if.sv - instruction memory request/response bundle
//
// Purpose: groups the word-fetch bus between arm7tdmi_fetch and instruction memory.
// Signals:
//   mem_req    fetch side -> memory  word read request
//   mem_addr   fetch side -> memory  word-aligned address, held until acked
//   mem_ack    memory -> fetch side  request accepted, mem_rdata valid this cycle
//   mem_rdata  memory -> fetch side  fetched little-endian word
// Modports: master = fetch unit, slave = instruction memory.

interface arm7tdmi_fetch_if;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_ack,
        output mem_rdata
    );
endinterface

// File: rtl/arm7tdmi_fetch.sv
// rtl/arm7tdmi_fetch.sv - instruction fetch and prefetch queue for the decode stage
//
// Purpose: issues word reads to instruction memory, buffers returned words in a
// DEPTH-entry first-word-fall-through queue, and presents one ARM word or Thumb
// halfword per cycle to decode. Redirects to branch_target on flush.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   mem             arm7tdmi_fetch_if.master, instruction memory bus
//   stall           decode cannot accept; hold the head instruction
//   flush           drop queued and in-flight data, redirect to branch_target
//   branch_target   redirect address, bit 0 ignored, bit 1 selects Thumb half
//   thumb_mode      1 = issue halfwords, 0 = issue words
//   instruction     head instruction (Thumb: zero-extended halfword)
//   pc_out          address of instruction
//   instr_valid     instruction/pc_out valid

module arm7tdmi_fetch #(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    arm7tdmi_fetch_if.master        mem,
    input  logic                    stall,
    input  logic                    flush,
    input  logic [31:0]             branch_target,
    input  logic                    thumb_mode,
    output logic [31:0]             instruction,
    output logic [31:0]             pc_out,
    output logic                    instr_valid
);

    localparam int          PW         = $clog2(DEPTH);
    localparam int          CW         = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [31:0] RESET_PC_W = RESET_PC & 32'hFFFF_FFFC;

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   word_q [DEPTH];
    logic [31:0]   word_d [DEPTH];
    logic [31:0]   addr_q [DEPTH];
    logic [31:0]   addr_d [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          half_sel_q, half_sel_d;

    logic          has_data;
    logic          can_req;
    logic          accept;
    logic          consume;
    logic          pop;
    logic [31:0]   head_word;
    logic [31:0]   head_addr;

    assign has_data  = (count_q != '0);
    // State updates use can_req without rst_n; flops are held in reset anyway,
    // and rst_n only gates the visible request so it drops asynchronously.
    assign can_req   = (count_q < DEPTH_C) && !flush;
    assign accept    = can_req && mem.mem_ack;
    assign head_word = word_q[rd_ptr_q];
    assign head_addr = addr_q[rd_ptr_q];

    assign mem.mem_req  = rst_n && can_req;
    assign mem.mem_addr = fetch_pc_q;
    assign instr_valid  = has_data && !flush;
    assign consume      = instr_valid && !stall;
    // A Thumb word is only released after its upper halfword has issued.
    assign pop          = consume && (!thumb_mode || half_sel_q);

    always_comb begin
        instruction = 32'h0;
        pc_out      = 32'h0;
        if (has_data) begin
            if (thumb_mode) begin
                instruction = {16'h0, half_sel_q ? head_word[31:16] : head_word[15:0]};
                pc_out      = head_addr | {30'b0, half_sel_q, 1'b0};
            end else begin
                instruction = head_word;
                pc_out      = head_addr;
            end
        end
    end

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        word_d     = word_q;
        addr_d     = addr_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        half_sel_d = half_sel_q;

        if (flush) begin
            // Any word acked this cycle is dropped by simply not enqueuing it.
            fetch_pc_d = {branch_target[31:2], 2'b00};
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
            half_sel_d = thumb_mode & branch_target[1];
        end else begin
            if (accept) begin
                word_d[wr_ptr_q] = mem.mem_rdata;
                addr_d[wr_ptr_q] = fetch_pc_q;
                wr_ptr_d         = wr_ptr_q + PW'(1);
                fetch_pc_d       = fetch_pc_q + 32'd4;
            end
            if (consume && thumb_mode) begin
                half_sel_d = !half_sel_q;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(accept) - CW'(pop);
            if (!thumb_mode) begin
                half_sel_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q <= RESET_PC_W;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            half_sel_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                word_q[i] <= 32'h0;
                addr_q[i] <= 32'h0;
            end
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            half_sel_q <= half_sel_d;
            word_q     <= word_d;
            addr_q     <= addr_d;
        end
    end

endmodule
